raster_timing: RTL and testbench
================================

RASTER_TIMING -- requirements
Module: raster_timing

Interface
REQ-001 SHALL have parameter HRES, default 1280, active pixels per line.
REQ-002 SHALL have parameter VRES, default 720, active lines per frame.
REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 110/40/220, horizontal front porch/sync/back porch in pixels.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 5/5/20, vertical front porch/sync/back porch in lines.
REQ-005 SHALL have parameter SYNC_POL, default 1, sync asserted level (1 = active-high).
REQ-006 SHALL have port pixel_clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, 1, pixel clock-enable; counters advance only when high.
REQ-009 SHALL have port hpos, output, signed 12, horizontal coordinate; 0..HRES-1 in active video.
REQ-010 SHALL have port vpos, output, signed 12, vertical coordinate; 0..VRES-1 in active video.
REQ-011 SHALL have ports hsync and vsync, output, 1 each, sync pulses at SYNC_POL level.
REQ-012 SHALL have port de, output, 1, high exactly when hpos>=0 and vpos>=0.
REQ-013 SHALL have port fsync, output, 1, one-cycle frame-start strobe for object update logic.

Function
REQ-014 SHALL define H_START = -(H_FP+H_SYNC+H_BP) and V_START = -(V_FP+V_SYNC+V_BP); 720p defaults give -370 and -30.
REQ-015 SHALL, per en-high cycle, increment hpos; at hpos==HRES-1 wrap hpos to H_START and increment vpos.
REQ-016 SHALL, when hpos wraps and vpos==VRES-1, wrap vpos to V_START. Frame period is 1650x750 enabled cycles at defaults.
REQ-017 SHALL, when en low, hold hpos, vpos, hsync, vsync and de, and drive fsync low.
REQ-018 SHALL run one horizontal phase FSM, H_FP -> H_SYNC -> H_BP -> H_ACTIVE -> H_FP, advancing at hpos == H_START+H_FP-1, H_START+H_FP+H_SYNC-1, -1 and HRES-1.
REQ-019 SHALL run one vertical phase FSM, V_FP -> V_SYNC -> V_BP -> V_ACTIVE -> V_FP, advancing only on horizontal wrap at the analogous vpos thresholds.
REQ-020 SHALL assert hsync for hpos in [H_START+H_FP, H_START+H_FP+H_SYNC-1] ([-260,-221] at defaults), on all lines.
REQ-021 SHALL assert vsync for vpos in [V_START+V_FP, V_START+V_FP+V_SYNC-1] ([-25,-21] at defaults), for whole lines.
REQ-022 SHALL register all outputs so hsync/vsync/de/fsync correspond to the hpos/vpos presented in the same cycle (zero skew).
REQ-023 SHALL assert fsync for exactly one cycle when hpos==H_START and vpos==V_START with en high, once per frame.
REQ-024 SHALL never present hpos outside [H_START, HRES-1] or vpos outside [V_START, VRES-1].

Reset
REQ-025 SHALL, while rst high, drive hpos=H_START, vpos=V_START, de=0, fsync=0, hsync=vsync=!SYNC_POL, and both FSMs in FP state.
REQ-026 SHALL give rst priority over en; reset mid-line or mid-frame restarts at frame start with no partial pulse.
REQ-027 SHALL, on the first en-high cycle after rst falls, present hpos=H_START+1. The frame-start fsync is taken at the H_START,V_START position on the following frame boundary.

Configuration
REQ-028 SHALL, with RASTER_FRAME_CNT_EN defined, add output frame_cnt (unsigned 16), reset 0, incremented with each fsync and wrapping 65535 -> 0.
REQ-029 SHALL, without RASTER_FRAME_CNT_EN, omit the frame_cnt port and its logic entirely.

Structure
REQ-030 SHALL place the phase enum (FP, SYNC, BP, ACTIVE) and the 720p default timing constants in shared package raster_pkg.
REQ-031 SHALL implement each axis as sub-module raster_axis (counter, phase FSM, sync compare), instantiated twice.
REQ-032 SHALL feed the vertical instance's advance strobe from the horizontal instance's wrap output gated by en.

Verification
REQ-033 SHALL check: rst then en=1 for 1650x750 cycles -> hpos cycles -370..1279, vpos -30..719, exactly one fsync.
REQ-034 SHALL check: count hsync width per line -> 40 cycles starting at hpos=-260; vsync spans vpos -25..-21 = 5x1650 cycles.
REQ-035 SHALL check: de count per frame -> 921600 (1280x720); de low whenever hpos<0 or vpos<0.
REQ-036 SHALL check: en toggled 1/0 every cycle -> frame takes 2x1650x750 cycles; outputs frozen on en-low cycles; fsync never during en low.
REQ-037 SHALL check: rst pulsed at hpos=500,vpos=300 -> next cycle hpos=-370, vpos=-30, all strobes deasserted.
REQ-038 SHALL check: RASTER_FRAME_CNT_EN build, 3 frames after reset -> frame_cnt reads 1,2,3 after successive fsync; preloaded model at 65535 wraps to 0.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared phase encoding and default 720p timing for the raster timing generator.
package raster_pkg;

  localparam int POS_W = 12;

  localparam int DEF_HRES   = 1280;
  localparam int DEF_VRES   = 720;
  localparam int DEF_H_FP   = 110;
  localparam int DEF_H_SYNC = 40;
  localparam int DEF_H_BP   = 220;
  localparam int DEF_V_FP   = 5;
  localparam int DEF_V_SYNC = 5;
  localparam int DEF_V_BP   = 20;

  typedef enum logic [1:0] {
    PH_FP,
    PH_SYNC,
    PH_BP,
    PH_ACTIVE
  } phase_e;

endpackage

// File: rtl/raster_axis.sv
// One raster axis: signed position counter running START..ACTIVE-1 with its
// phase FSM. Sync and active flags are registered alongside the position.
module raster_axis
  import raster_pkg::*;
#(
  parameter int ACTIVE   = DEF_HRES,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter int SYNC_POL = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    adv_i,
  output logic signed [POS_W-1:0] pos_o,
  output logic                    sync_o,
  output logic                    active_o,
  output logic                    wrap_o
);

  localparam logic signed [POS_W-1:0] START    = POS_W'(-(FP + SYNC + BP));
  localparam logic signed [POS_W-1:0] FP_END   = POS_W'(-(SYNC + BP) - 1);
  localparam logic signed [POS_W-1:0] SYNC_END = POS_W'(-BP - 1);
  localparam logic signed [POS_W-1:0] BP_END   = POS_W'(-1);
  localparam logic signed [POS_W-1:0] ACT_END  = POS_W'(ACTIVE - 1);
  localparam logic signed [POS_W-1:0] ONE      = POS_W'(1);
  localparam logic                    POL      = (SYNC_POL != 0);

  logic signed [POS_W-1:0] pos_q;
  phase_e                  state_q;
  logic                    sync_q;
  logic                    active_q;

  assign wrap_o   = adv_i && (pos_q == ACT_END);
  assign pos_o    = pos_q;
  assign sync_o   = sync_q;
  assign active_o = active_q;

  // Outputs change on the same edge as the phase they describe, so they line up with pos_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q    <= START;
      state_q  <= PH_FP;
      sync_q   <= !POL;
      active_q <= 1'b0;
    end else if (adv_i) begin
      pos_q <= wrap_o ? START : pos_q + ONE;
      case (state_q)
        PH_FP: if (pos_q == FP_END) begin
          state_q <= PH_SYNC;
          sync_q  <= POL;
        end
        PH_SYNC: if (pos_q == SYNC_END) begin
          state_q <= PH_BP;
          sync_q  <= !POL;
        end
        PH_BP: if (pos_q == BP_END) begin
          state_q  <= PH_ACTIVE;
          active_q <= 1'b1;
        end
        PH_ACTIVE: if (pos_q == ACT_END) begin
          state_q  <= PH_FP;
          active_q <= 1'b0;
        end
        default: state_q <= PH_FP;
      endcase
    end
  end

endmodule

// File: rtl/raster_timing.sv
// Raster timing generator: horizontal and vertical raster_axis instances plus a frame strobe.
// Define RASTER_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module raster_timing
  import raster_pkg::*;
#(
  parameter int HRES     = DEF_HRES,
  parameter int VRES     = DEF_VRES,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 1
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    en,
  output logic signed [POS_W-1:0] hpos,
  output logic signed [POS_W-1:0] vpos,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    fsync
`ifdef RASTER_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  logic hWrap;
  logic vWrap;
  logic hActive;
  logic vActive;
  logic fsync_q;

  raster_axis #(
    .ACTIVE(HRES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h_axis (
    .clk_i(pixel_clk), .rst_i(rst), .adv_i(en),
    .pos_o(hpos), .sync_o(hsync), .active_o(hActive), .wrap_o(hWrap)
  );

  // The vertical axis steps once per line, on the enabled horizontal wrap.
  raster_axis #(
    .ACTIVE(VRES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v_axis (
    .clk_i(pixel_clk), .rst_i(rst), .adv_i(hWrap),
    .pos_o(vpos), .sync_o(vsync), .active_o(vActive), .wrap_o(vWrap)
  );

  assign de    = hActive && vActive;
  assign fsync = fsync_q;

  // Both axes wrapping together means the next position presented is the frame start.
  always_ff @(posedge pixel_clk) begin
    if (rst) fsync_q <= 1'b0;
    else     fsync_q <= hWrap && vWrap;
  end

`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] frameCnt_q;
  assign frame_cnt = frameCnt_q;

  always_ff @(posedge pixel_clk) begin
    if (rst)                 frameCnt_q <= 16'd0;
    else if (hWrap && vWrap) frameCnt_q <= frameCnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_raster_timing.sv
// Directed bench for raster_timing using a reduced raster (16x8 active, 28x15 total).
module tb_raster_timing;

  localparam int HRES = 16, VRES = 8;
  localparam int HFP = 3, HSY = 4, HBP = 5;
  localparam int VFP = 2, VSY = 2, VBP = 3;
  localparam int HS = -12, VS = -7;
  localparam int HSYNC_LO = -9, HSYNC_HI = -6;
  localparam int VSYNC_LO = -5, VSYNC_HI = -4;
  localparam int FRAME = 420;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic hsync, vsync, de, fsync;
`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int total = 0;
  int bad = 0;
  int mH, mV;

  raster_timing #(
    .HRES(HRES), .VRES(VRES),
    .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1)
  ) dut (
    .pixel_clk(clk), .rst(rst), .en(en),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .de(de), .fsync(fsync)
`ifdef RASTER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input logic enV);
    @(negedge clk);
    en = enV;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mH = HS;
    mV = VS;
  endtask

  task automatic modelStep();
    if (mH == HRES - 1) begin
      mH = HS;
      mV = (mV == VRES - 1) ? VS : mV + 1;
    end else begin
      mH = mH + 1;
    end
  endtask

  task automatic test_reset();
    int h, v;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    h = hpos; v = vpos;
    total++; if (h !== HS) begin bad++; $display("[TB] FAIL reset_hpos got=%0d want=%0d", h, HS); end
    total++; if (v !== VS) begin bad++; $display("[TB] FAIL reset_vpos got=%0d want=%0d", v, VS); end
    total++; if (de !== 1'b0) begin bad++; $display("[TB] FAIL reset_de got=%b want=0", de); end
    total++; if (fsync !== 1'b0) begin bad++; $display("[TB] FAIL reset_fsync got=%b want=0", fsync); end
    total++; if (hsync !== 1'b0) begin bad++; $display("[TB] FAIL reset_hsync got=%b want=0", hsync); end
    total++; if (vsync !== 1'b0) begin bad++; $display("[TB] FAIL reset_vsync got=%b want=0", vsync); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    h = hpos; v = vpos;
    total++; if (h !== HS + 1) begin bad++; $display("[TB] FAIL first_en_hpos got=%0d want=%0d", h, HS + 1); end
    total++; if (v !== VS) begin bad++; $display("[TB] FAIL first_en_vpos got=%0d want=%0d", v, VS); end
    total++; if (fsync !== 1'b0) begin bad++; $display("[TB] FAIL first_en_fsync got=%b want=0", fsync); end
  endtask

  task automatic test_frame();
    int h, v, fsCnt, deCnt, hsCnt, vsCnt, errs;
    logic eHs, eVs, eDe, eFs;
    fsCnt = 0; deCnt = 0; hsCnt = 0; vsCnt = 0; errs = 0;
    doReset();
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      modelStep();
      h = hpos; v = vpos;
      eHs = (mH >= HSYNC_LO) && (mH <= HSYNC_HI);
      eVs = (mV >= VSYNC_LO) && (mV <= VSYNC_HI);
      eDe = (mH >= 0) && (mV >= 0);
      eFs = (mH == HS) && (mV == VS);
      if (fsync === 1'b1) fsCnt++;
      if (de === 1'b1) deCnt++;
      if (hsync === 1'b1) hsCnt++;
      if (vsync === 1'b1) vsCnt++;
      total++;
      if (h !== mH || v !== mV || hsync !== eHs || vsync !== eVs || de !== eDe || fsync !== eFs) begin
        bad++;
        if (errs < 8)
          $display("[TB] FAIL frame_cycle%0d got h=%0d v=%0d hs=%b vs=%b de=%b fs=%b want h=%0d v=%0d hs=%b vs=%b de=%b fs=%b",
                   i, h, v, hsync, vsync, de, fsync, mH, mV, eHs, eVs, eDe, eFs);
        errs++;
      end
    end
    total++; if (fsCnt !== 1) begin bad++; $display("[TB] FAIL frame_fsync_count got=%0d want=1", fsCnt); end
    total++; if (deCnt !== HRES * VRES) begin bad++; $display("[TB] FAIL frame_de_count got=%0d want=%0d", deCnt, HRES * VRES); end
    total++; if (hsCnt !== HSY * 15) begin bad++; $display("[TB] FAIL frame_hsync_count got=%0d want=%0d", hsCnt, HSY * 15); end
    total++; if (vsCnt !== VSY * 28) begin bad++; $display("[TB] FAIL frame_vsync_count got=%0d want=%0d", vsCnt, VSY * 28); end
    total++; if (fsync !== 1'b1) begin bad++; $display("[TB] FAIL frame_end_fsync got=%b want=1", fsync); end
  endtask

  task automatic test_enable_toggle();
    int h, v, pH, pV, fsCnt, errs;
    logic pHs, pVs, pDe;
    fsCnt = 0; errs = 0;
    doReset();
    pH = HS; pV = VS; pHs = 1'b0; pVs = 1'b0; pDe = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((i % 2) == 0) begin
        tick(1'b1);
        modelStep();
        h = hpos; v = vpos;
        total++;
        if (h !== mH || v !== mV || fsync !== ((mH == HS) && (mV == VS))) begin
          bad++;
          if (errs < 8) $display("[TB] FAIL toggle_en_hi%0d got h=%0d v=%0d fs=%b want h=%0d v=%0d", i, h, v, fsync, mH, mV);
          errs++;
        end
        if (fsync === 1'b1) fsCnt++;
      end else begin
        tick(1'b0);
        h = hpos; v = vpos;
        total++;
        if (h !== pH || v !== pV || hsync !== pHs || vsync !== pVs || de !== pDe || fsync !== 1'b0) begin
          bad++;
          if (errs < 8) $display("[TB] FAIL toggle_en_lo%0d got h=%0d v=%0d fs=%b want h=%0d v=%0d fs=0", i, h, v, fsync, pH, pV);
          errs++;
        end
      end
      pH = hpos; pV = vpos; pHs = hsync; pVs = vsync; pDe = de;
    end
    h = hpos; v = vpos;
    total++; if (fsCnt !== 1) begin bad++; $display("[TB] FAIL toggle_fsync_count got=%0d want=1", fsCnt); end
    total++; if (h !== HS || v !== VS) begin bad++; $display("[TB] FAIL toggle_end_pos got=%0d,%0d want=%0d,%0d", h, v, HS, VS); end
  endtask

  task automatic test_reset_mid();
    int h, v, n;
    doReset();
    n = 0;
    while (!(hpos == 12'sd5 && vpos == 12'sd3) && n < FRAME) begin
      tick(1'b1);
      n++;
    end
    total++; if (n >= FRAME) begin bad++; $display("[TB] FAIL midreset_reach got=timeout want=h5_v3"); end
    total++; if (de !== 1'b1) begin bad++; $display("[TB] FAIL midreset_pre_de got=%b want=1", de); end
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    h = hpos; v = vpos;
    total++; if (h !== HS || v !== VS) begin bad++; $display("[TB] FAIL midreset_pos got=%0d,%0d want=%0d,%0d", h, v, HS, VS); end
    total++;
    if (de !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0 || fsync !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_strobes got de=%b hs=%b vs=%b fs=%b want all 0", de, hsync, vsync, fsync);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    h = hpos;
    total++; if (h !== HS + 1) begin bad++; $display("[TB] FAIL midreset_restart got=%0d want=%0d", h, HS + 1); end
  endtask

`ifdef RASTER_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int k;
    k = 0;
    doReset();
    tick(1'b0);
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("[TB] FAIL fcnt_reset got=%0d want=0", frame_cnt); end
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(1'b1);
      if (fsync === 1'b1) begin
        k++;
        total++;
        if (frame_cnt !== 16'(k)) begin bad++; $display("[TB] FAIL fcnt_frame%0d got=%0d want=%0d", k, frame_cnt, k); end
      end
    end
    total++; if (k !== 3) begin bad++; $display("[TB] FAIL fcnt_fsyncs got=%0d want=3", k); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_frame();
    test_enable_toggle();
    test_reset_mid();
`ifdef RASTER_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
